exception_controller: RTL and testbench
=======================================

# exception_controller

Registered, parametrised exception unit for the RISC-V processor core. It detects stack underflow/overflow, out-of-range data-memory addresses and up to twelve external exception sources, then resolves them by fixed priority. It latches the winning cause and the faulting PC, issues a one-cycle pipeline flush, and holds the exception pending until the trap handler acknowledges it. It sits beside the stack-pointer unit and the data-memory stage and feeds the control unit and the PC mux.

## Interface
- SP_WIDTH, `SP_WIDTH: stack-pointer width
- ADDR_WIDTH, 16: data-memory address width
- MEM_LIMIT, 'hFF00: highest legal data address; any address above it faults
- PC_WIDTH, 16: program-counter width
- NUM_EXT, 2: number of external exception inputs, 0..12
- CNT_WIDTH, 8: width of the exception counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stack_op  in  1  push/pop issued this cycle
- sp_o  in  SP_WIDTH  current stack pointer
- sp_step_sign  in  1  1 = push (SP decrements), 0 = pop
- mem_access  in  1  load/store issued this cycle
- mem_address  in  ADDR_WIDTH  data address of the access
- pc  in  PC_WIDTH  PC of the instruction in the faulting stage
- ext_exc  in  NUM_EXT  external exception requests, level, sampled each cycle
- exc_mask  in  NUM_EXT+3  1 enables source i (the index is defined below)
- exc_ack  in  1  handler acknowledge
- ovr_clr  in  1  clears exc_overrun
- exc_pending  out  1  an exception is latched and not yet acknowledged
- exc_flush  out  1  one-cycle pulse on entry to PENDING
- exc_cause  out  4  latched cause code; 0 means none
- epc  out  PC_WIDTH  latched faulting PC
- exc_overrun  out  1  sticky; an exception was lost while PENDING
- exc_count  out  CNT_WIDTH  saturating count of accepted exceptions

## Operation
- Source index i, cause code = i+1, priority runs lowest index first:
  - 0, stack underflow: stack_op & ~sp_step_sign & (sp_o == all ones), i.e. a pop on an empty stack.
  - 1, stack overflow: stack_op & sp_step_sign & (sp_o == 0).
  - 2, invalid address: mem_access & (mem_address > MEM_LIMIT); unsigned compare; MEM_LIMIT itself is legal.
  - 3+k, external: ext_exc[k].
- A source counts only when its exc_mask bit is 1. The raw source vector ANDed with the mask is the request vector.
- The FSM has two states, IDLE and PENDING.
- IDLE, request vector ≠ 0, at the clock edge:
  - go to PENDING;
  - exc_cause <= code of the highest-priority request;
  - epc <= pc;
  - exc_flush <= 1;
  - exc_count increments and saturates at all ones.
- Lower-priority requests in the same cycle are discarded. They do not set overrun.
- PENDING:
  - exc_flush returns to 0 after one cycle.
  - A request at an edge sets exc_overrun. It is not captured and is not counted.
  - exc_ack = 1 at an edge: go to IDLE and clear exc_cause to 0. epc holds its value.
- PENDING with ack and a request at the same edge: the ack wins, the request sets exc_overrun, the FSM ends in IDLE.
- exc_ack in IDLE is ignored.
- ovr_clr clears exc_overrun. If it coincides with a new overrun event, the set wins.

## Timing
- Detection is combinational from the inputs. All outputs are registered, so latency is 1 cycle from request to exc_pending, exc_flush, exc_cause and epc.
- exc_pending = (state == PENDING) and is driven directly from the state register.
- A level request held across the ack edge is lost as an overrun. It re-enters on the next edge if it is still present in IDLE.
- Minimum spacing between two accepted exceptions is 2 cycles: one accept edge, one ack edge, then the next accept edge.
- Reset values: state IDLE; exc_pending 0; exc_flush 0; exc_cause 0; epc 0; exc_overrun 0; exc_count 0.
- Reset applied mid-PENDING aborts immediately, asynchronously, with no flush pulse.

## Test plan
- SP_WIDTH=8, sp_o=8'hFF, stack_op=1, sp_step_sign=0, pc=16'h0040, all masks 1 -> next cycle: exc_pending=1, exc_cause=1, epc=16'h0040, exc_flush=1 for exactly one cycle, exc_count=1.
- mem_access=1 with mem_address=16'hFF00, then 16'hFF01 -> no exception at FF00; at FF01 exc_cause=3; with exc_mask[2]=0, FF01 raises nothing.
- Overflow (sp_o=0, push) together with ext_exc[0]=1 in the same cycle -> exc_cause=2, exc_overrun stays 0; ack -> exc_cause=0, exc_pending=0, epc unchanged.
- While PENDING, pulse ext_exc[1] and exc_ack together -> IDLE next cycle, exc_overrun=1, exc_count unchanged; ovr_clr -> exc_overrun=0.
- CNT_WIDTH=2, accept and ack 5 exceptions -> exc_count reads 1, 2, 3, 3, 3.
- Assert rst_n=0 mid-cycle while PENDING -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exception_controller.sv
`default_nettype none
// ============================================================================
// Module   : exception_controller
// Brief    : Fixed-priority exception detector/latcher with flush, ack,
//            overrun and saturating exception count.
// Revision : 1.0 - initial release
// ============================================================================
module exception_controller #(
    parameter int SP_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT = 'hFF00,
    parameter int PC_WIDTH   = 16,
    parameter int NUM_EXT    = 2,
    parameter int CNT_WIDTH  = 8,
    // Physical width of ext_exc; one dummy bit is kept when NUM_EXT is 0.
    localparam int EXT_W     = (NUM_EXT > 0) ? NUM_EXT : 1,
    localparam int NSRC      = NUM_EXT + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stack_op,
    input  logic [SP_WIDTH-1:0]   sp_o,
    input  logic                  sp_step_sign,
    input  logic                  mem_access,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [EXT_W-1:0]      ext_exc,
    input  logic [NSRC-1:0]       exc_mask,
    input  logic                  exc_ack,
    input  logic                  ovr_clr,
    output logic                  exc_pending,
    output logic                  exc_flush,
    output logic [3:0]            exc_cause,
    output logic [PC_WIDTH-1:0]   epc,
    output logic                  exc_overrun,
    output logic [CNT_WIDTH-1:0]  exc_count
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NSRC-1:0]       w_raw;
    logic [NSRC-1:0]       w_req;
    logic                  w_any;
    logic [3:0]            w_code;
    logic [SP_WIDTH-1:0]   w_sp_full;

    assign w_sp_full = {SP_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Source detection
    // ------------------------------------------------------------------
    assign w_raw[0] = stack_op & ~sp_step_sign & (sp_o == w_sp_full);
    assign w_raw[1] = stack_op &  sp_step_sign & (sp_o == '0);
    assign w_raw[2] = mem_access & (mem_address > MEM_LIMIT);

    generate
        if (NUM_EXT > 0) begin : g_ext
            assign w_raw[NSRC-1:3] = ext_exc[NUM_EXT-1:0];
        end else begin : g_no_ext
            logic w_ext_unused;
            assign w_ext_unused = &ext_exc;
        end
    endgenerate

    assign w_req = w_raw & exc_mask;
    assign w_any = |w_req;

    // Scan from highest index down so the lowest active index wins.
    always_comb begin
        w_code = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_code = 4'(i + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)   w_state_nxt = PENDING;
            PENDING: if (exc_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign exc_pending = (r_state == PENDING);

    // ------------------------------------------------------------------
    // Latched outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_flush <= 1'b0;
            exc_cause <= 4'd0;
            epc       <= '0;
            exc_count <= '0;
        end else begin
            exc_flush <= (r_state == IDLE) && w_any;
            if (r_state == IDLE) begin
                if (w_any) begin
                    exc_cause <= w_code;
                    epc       <= pc;
                    if (exc_count != c_cnt_max) begin
                        exc_count <= exc_count + 1'b1;
                    end
                end
            end else if (exc_ack) begin
                exc_cause <= 4'd0;
            end
        end
    end

    // Set takes precedence over clear when both occur on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_overrun <= 1'b0;
        end else if ((r_state == PENDING) && w_any) begin
            exc_overrun <= 1'b1;
        end else if (ovr_clr) begin
            exc_overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exception_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_controller
// Brief    : Directed self-checking bench for exception_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_controller;

    logic        clk;
    logic        rst_n;
    logic        stack_op;
    logic [7:0]  sp_o;
    logic        sp_step_sign;
    logic        mem_access;
    logic [15:0] mem_address;
    logic [15:0] pc;
    logic [1:0]  ext_exc;
    logic [4:0]  exc_mask;
    logic        exc_ack;
    logic        ovr_clr;
    logic        exc_pending;
    logic        exc_flush;
    logic [3:0]  exc_cause;
    logic [15:0] epc;
    logic        exc_overrun;
    logic [1:0]  exc_count;

    int r_total = 0;
    int r_bad   = 0;

    exception_controller #(
        .SP_WIDTH   (8),
        .ADDR_WIDTH (16),
        .MEM_LIMIT  (16'hFF00),
        .PC_WIDTH   (16),
        .NUM_EXT    (2),
        .CNT_WIDTH  (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stack_op     (stack_op),
        .sp_o         (sp_o),
        .sp_step_sign (sp_step_sign),
        .mem_access   (mem_access),
        .mem_address  (mem_address),
        .pc           (pc),
        .ext_exc      (ext_exc),
        .exc_mask     (exc_mask),
        .exc_ack      (exc_ack),
        .ovr_clr      (ovr_clr),
        .exc_pending  (exc_pending),
        .exc_flush    (exc_flush),
        .exc_cause    (exc_cause),
        .epc          (epc),
        .exc_overrun  (exc_overrun),
        .exc_count    (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt [5];
        exp_cnt = '{1, 2, 3, 3, 3};

        rst_n        = 1'b0;
        stack_op     = 1'b0;
        sp_o         = 8'h10;
        sp_step_sign = 1'b0;
        mem_access   = 1'b0;
        mem_address  = 16'h0000;
        pc           = 16'h0000;
        ext_exc      = 2'b00;
        exc_mask     = 5'b11111;
        exc_ack      = 1'b0;
        ovr_clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pending", exc_pending, 0);
        check("rst_flush",   exc_flush,   0);
        check("rst_cause",   exc_cause,   0);
        check("rst_epc",     epc,         0);
        check("rst_overrun", exc_overrun, 0);
        check("rst_count",   exc_count,   0);
        rst_n = 1'b1;

        // Stack underflow: pop with SP at all ones
        sp_o = 8'hFF; stack_op = 1'b1; sp_step_sign = 1'b0; pc = 16'h0040;
        tick();
        check("uf_pending", exc_pending, 1);
        check("uf_cause",   exc_cause,   1);
        check("uf_epc",     epc,         16'h0040);
        check("uf_flush",   exc_flush,   1);
        check("uf_count",   exc_count,   1);
        stack_op = 1'b0; pc = 16'h0044;
        tick();
        check("uf_flush_one", exc_flush,   0);
        check("uf_hold",      exc_pending, 1);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("uf_ack_pending", exc_pending, 0);
        check("uf_ack_cause",   exc_cause,   0);
        check("uf_ack_epc",     epc,         16'h0040);

        // External source 1, then overrun from ext 0 coincident with ack
        ext_exc = 2'b10; pc = 16'h0100;
        tick();
        check("ext1_cause", exc_cause, 5);
        check("ext1_count", exc_count, 2);
        ext_exc = 2'b01; exc_ack = 1'b1;
        tick();
        ext_exc = 2'b00; exc_ack = 1'b0;
        check("ovr_pending", exc_pending, 0);
        check("ovr_set",     exc_overrun, 1);
        check("ovr_count",   exc_count,   2);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", exc_overrun, 0);

        // Address boundary: MEM_LIMIT is legal, one above faults
        mem_access = 1'b1; mem_address = 16'hFF00; pc = 16'h0200;
        tick();
        check("addr_ff00", exc_pending, 0);
        mem_address = 16'hFF01;
        tick();
        mem_access = 1'b0;
        check("addr_ff01_cause", exc_cause, 3);
        check("addr_ff01_count", exc_count, 3);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        exc_mask = 5'b11011; mem_access = 1'b1;
        tick();
        mem_access = 1'b0; exc_mask = 5'b11111;
        check("addr_masked", exc_pending, 0);

        // Overflow together with ext 0: overflow wins, no overrun
        stack_op = 1'b1; sp_step_sign = 1'b1; sp_o = 8'h00; ext_exc = 2'b01; pc = 16'h1234;
        tick();
        stack_op = 1'b0; ext_exc = 2'b00; pc = 16'h5555;
        check("of_cause",   exc_cause,   2);
        check("of_overrun", exc_overrun, 0);
        check("of_epc",     epc,         16'h1234);
        check("of_count_sat", exc_count, 3);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("of_ack_cause",   exc_cause,   0);
        check("of_ack_pending", exc_pending, 0);
        check("of_ack_epc",     epc,         16'h1234);

        // Asynchronous reset in the middle of PENDING while flush is high
        ext_exc = 2'b01; pc = 16'h0300;
        tick();
        ext_exc = 2'b00;
        check("ar_pre_pending", exc_pending, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pending", exc_pending, 0);
        check("ar_flush",   exc_flush,   0);
        check("ar_cause",   exc_cause,   0);
        check("ar_epc",     epc,         0);
        check("ar_count",   exc_count,   0);
        #1;
        rst_n = 1'b1;

        // Saturating counter across five accept/ack pairs
        mem_address = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            mem_access = 1'b1;
            tick();
            mem_access = 1'b0;
            check($sformatf("sat_count_%0d", k), exc_count, exp_cnt[k]);
            exc_ack = 1'b1;
            tick();
            exc_ack = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
